// File: rtl/eth_wb_cfg_arbiter_if.sv
// ---------------------------------------------------------------------------
// eth_wb_cfg_arbiter_if
// Bundles the requester-side handshake and the Wishbone master bus of the
// Ethernet MAC register-port arbiter.
//   master modport : the arbiter (samples requests and WB read data, drives
//                    grant/done/err/rdata and the WB master signals)
//   slave modport  : the environment (requesters plus the WB slave)
// Requester-side signals:
//   req_i, req_we_i          per-requester request and write enable
//   req_adr_i, req_dat_i     packed per-requester address / write data,
//                            requester i at [i*W +: W]
//   gnt_o, done_o, err_o     one-hot owner, completion pulse, timeout pulse
//   rdata_o                  last read data, held until the next completion
// Wishbone-side signals:
//   wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_dat_i, wb_ack_i
// ---------------------------------------------------------------------------
interface eth_wb_cfg_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*ADDR_W-1:0] req_adr_i;
    logic [NUM_REQ*DATA_W-1:0] req_dat_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic [NUM_REQ-1:0]        err_o;
    logic [DATA_W-1:0]         rdata_o;

    logic [ADDR_W-1:0]         wb_adr_o;
    logic [DATA_W-1:0]         wb_dat_o;
    logic                      wb_we_o;
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic [DATA_W-1:0]         wb_dat_i;
    logic                      wb_ack_i;

    modport master (
        input  req_i, req_we_i, req_adr_i, req_dat_i, wb_dat_i, wb_ack_i,
        output gnt_o, done_o, err_o, rdata_o,
               wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output req_i, req_we_i, req_adr_i, req_dat_i, wb_dat_i, wb_ack_i,
        input  gnt_o, done_o, err_o, rdata_o,
               wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/eth_wb_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// eth_wb_cfg_arbiter
// Round-robin arbiter and single-beat Wishbone master sequencer for the
// Ethernet MAC register port. NUM_REQ requesters share one WB slave; one
// transaction runs at a time, a slave that never acks is aborted after
// TIMEOUT bus cycles, and read data is returned to the owner.
// Ports:
//   wb_clk_i   clock, all logic on the rising edge
//   wb_rst_i   synchronous active-low reset
//   bus        eth_wb_cfg_arbiter_if.master (requests, grant/done/err,
//              read data, WB master signals); every output is registered
// Sequence: IDLE -> BUS -> DONE -> IDLE. gnt_o is held from the grant edge
// through the DONE cycle; done_o/err_o are high for the DONE cycle only.
// ---------------------------------------------------------------------------
module eth_wb_cfg_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    eth_wb_cfg_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // The counter is compared before it increments, so the abort fires on
    // the edge that would take it to TIMEOUT: cyc is high for TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    rr_r;
    logic [IDX_W-1:0]    owner_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [NUM_REQ-1:0]  done_r;
    logic [NUM_REQ-1:0]  err_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [ADDR_W-1:0]   adr_r;
    logic [DATA_W-1:0]   dat_r;
    logic                we_r;
    logic                cyc_r;

    logic                pick_vld_s;
    logic [IDX_W-1:0]    pick_idx_s;

    // Requester index base+offs modulo NUM_REQ; both operands are below
    // NUM_REQ, so one conditional subtract is enough.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    endfunction

    // Round-robin pick: scanning offsets from the far end down lets the
    // requester closest to the pointer overwrite any later candidate.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_i[wrap_idx(rr_r, k)]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = wrap_idx(rr_r, k);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Transaction sequencer: grant, run the WB cycle, complete or abort,
    // then advance the round-robin pointer past the owner.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_r <= ST_IDLE;
            rr_r    <= '0;
            owner_r <= '0;
            cnt_r   <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            err_r   <= '0;
            rdata_r <= '0;
            adr_r   <= '0;
            dat_r   <= '0;
            we_r    <= 1'b0;
            cyc_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        owner_r <= pick_idx_s;
                        gnt_r   <= onehot(pick_idx_s);
                        adr_r   <= bus.req_adr_i[pick_idx_s*ADDR_W +: ADDR_W];
                        dat_r   <= bus.req_dat_i[pick_idx_s*DATA_W +: DATA_W];
                        we_r    <= bus.req_we_i[pick_idx_s];
                        cyc_r   <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= ST_BUS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_BUS: begin
                    // Ack is tested first so that an ack on the last allowed
                    // cycle completes normally instead of aborting.
                    if (bus.wb_ack_i) begin
                        if (!we_r) begin
                            rdata_r <= bus.wb_dat_i;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        done_r  <= onehot(owner_r);
                        err_r   <= '0;
                        cyc_r   <= 1'b0;
                        adr_r   <= '0;
                        dat_r   <= '0;
                        we_r    <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        rdata_r <= '0;
                        done_r  <= onehot(owner_r);
                        err_r   <= onehot(owner_r);
                        cnt_r   <= cnt_r + CNT_W'(1);
                        cyc_r   <= 1'b0;
                        adr_r   <= '0;
                        dat_r   <= '0;
                        we_r    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_BUS;
                    end
                end

                ST_DONE: begin
                    rr_r    <= next_ptr(owner_r);
                    gnt_r   <= '0;
                    done_r  <= '0;
                    err_r   <= '0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    gnt_r   <= '0;
                    done_r  <= '0;
                    err_r   <= '0;
                    cyc_r   <= 1'b0;
                    adr_r   <= '0;
                    dat_r   <= '0;
                    we_r    <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o    = gnt_r;
    assign bus.done_o   = done_r;
    assign bus.err_o    = err_r;
    assign bus.rdata_o  = rdata_r;
    assign bus.wb_adr_o = adr_r;
    assign bus.wb_dat_o = dat_r;
    assign bus.wb_we_o  = we_r;
    assign bus.wb_cyc_o = cyc_r;
    assign bus.wb_stb_o = cyc_r;

endmodule

// File: tb/tb_eth_wb_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_wb_cfg_arbiter
// Self-checking bench for eth_wb_cfg_arbiter. A negedge process plays the
// WB slave (ack after a chosen delay), clears a requester's request once it
// sees that requester's done pulse, and logs every transaction start and
// every done pulse. The test tasks compare those logs against values the
// bench derives itself: directed cases plus randomized batches checked
// against a transaction-level round-robin / timeout model.
// ---------------------------------------------------------------------------
module tb_eth_wb_cfg_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        int                 cyc;
        logic [ADDR_W-1:0]  adr;
        logic [DATA_W-1:0]  dat;
        logic               we;
        logic [NUM_REQ-1:0] gnt;
        int                 delay;
        logic [DATA_W-1:0]  sdata;
    } start_t;

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] done;
        logic [NUM_REQ-1:0] err;
        logic [NUM_REQ-1:0] gnt;
        logic [DATA_W-1:0]  rdata;
        int                 bus_len;
        bit                 unstable;
    } comp_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    always #5 wb_clk_i = ~wb_clk_i;

    eth_wb_cfg_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    eth_wb_cfg_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (ifc)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [NUM_REQ-1:0] req_want   = '0;
    logic [NUM_REQ-1:0] req_served = '0;
    assign ifc.req_i = req_want & ~req_served;

    bit                auto_drop     = 1'b1;
    bit                slave_rand    = 1'b0;
    int                ack_delay_cfg = 0;
    logic [DATA_W-1:0] rd_data_cfg   = '0;

    int                cyc_n     = 0;
    int                bus_cnt   = 0;
    int                cur_delay = 0;
    logic [DATA_W-1:0] cur_data  = '0;
    logic              prev_cyc  = 1'b0;
    bit                unstable  = 1'b0;
    int                stb_bad   = 0;

    start_t start_q[$];
    comp_t  comp_q[$];

    // Slave model, requester auto-drop and transaction logger.
    always @(negedge wb_clk_i) begin : mon
        start_t s;
        comp_t  c;
        cyc_n = cyc_n + 1;
        if (ifc.wb_stb_o !== ifc.wb_cyc_o) stb_bad = stb_bad + 1;
        if (ifc.wb_cyc_o === 1'b1 && prev_cyc !== 1'b1) begin
            bus_cnt  = 1;
            unstable = 1'b0;
            if (slave_rand) begin
                cur_delay = $urandom_range(0, TIMEOUT + 2);
                cur_data  = $urandom;
            end else begin
                cur_delay = ack_delay_cfg;
                cur_data  = rd_data_cfg;
            end
            s.cyc = cyc_n; s.adr = ifc.wb_adr_o; s.dat = ifc.wb_dat_o;
            s.we = ifc.wb_we_o; s.gnt = ifc.gnt_o; s.delay = cur_delay; s.sdata = cur_data;
            start_q.push_back(s);
        end else if (ifc.wb_cyc_o === 1'b1) begin
            bus_cnt = bus_cnt + 1;
            if (ifc.wb_adr_o !== start_q[$].adr || ifc.wb_dat_o !== start_q[$].dat ||
                ifc.wb_we_o !== start_q[$].we)
                unstable = 1'b1;
        end
        if (ifc.wb_cyc_o === 1'b1) ifc.wb_ack_i = (bus_cnt == cur_delay + 1);
        else ifc.wb_ack_i = slave_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        ifc.wb_dat_i = cur_data;
        if ((|ifc.done_o) === 1'b1) begin
            c.cyc = cyc_n; c.done = ifc.done_o; c.err = ifc.err_o; c.gnt = ifc.gnt_o;
            c.rdata = ifc.rdata_o; c.bus_len = bus_cnt; c.unstable = unstable;
            comp_q.push_back(c);
            if (auto_drop) req_served = req_served | ifc.done_o;
        end
        req_served = req_served & req_want;
        prev_cyc   = ifc.wb_cyc_o;
    end

    task automatic wait_comps(input int target, input int budget, output bit ok);
        int n = 0;
        while (comp_q.size() < target && n < budget) begin
            @(negedge wb_clk_i);
            n++;
        end
        ok = (comp_q.size() >= target);
    endtask

    task automatic set_req(input int i, input bit we, input logic [ADDR_W-1:0] adr,
                           input logic [DATA_W-1:0] dat);
        ifc.req_we_i[i]                  = we;
        ifc.req_adr_i[i*ADDR_W +: ADDR_W] = adr;
        ifc.req_dat_i[i*DATA_W +: DATA_W] = dat;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b0;
        req_want = '0;
        repeat (3) @(negedge wb_clk_i);
        tests_run++;
        if ({ifc.wb_cyc_o, ifc.wb_stb_o, ifc.wb_we_o} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctl: got %b expected 000", {ifc.wb_cyc_o, ifc.wb_stb_o, ifc.wb_we_o});
        end
        tests_run++;
        if ({ifc.wb_adr_o, ifc.wb_dat_o} !== {ADDR_W'(0), DATA_W'(0)}) begin
            tests_failed++; $display("FAIL reset_adr_dat: got %h/%h expected 0", ifc.wb_adr_o, ifc.wb_dat_o);
        end
        tests_run++;
        if ({ifc.gnt_o, ifc.done_o, ifc.err_o} !== {3*NUM_REQ{1'b0}}) begin
            tests_failed++; $display("FAIL reset_gnt_done_err: got %b expected 0", {ifc.gnt_o, ifc.done_o, ifc.err_o});
        end
        tests_run++;
        if (ifc.rdata_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h expected 0", ifc.rdata_o);
        end
        wb_rst_i = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        tests_run++;
        if (ifc.wb_cyc_o !== 1'b0 || start_q.size() != 0) begin
            tests_failed++; $display("FAIL idle_no_req: cyc %b starts %0d expected 0/0", ifc.wb_cyc_o, start_q.size());
        end
    endtask

    task automatic test_write();
        int bs = start_q.size();
        int bc = comp_q.size();
        bit ok;
        set_req(0, 1'b1, 8'h40, 32'h0000_0005);
        slave_rand = 1'b0; ack_delay_cfg = 1; auto_drop = 1'b1;
        req_want = 2'b01;
        wait_comps(bc + 1, 60, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL write_wait: got %0d completions expected %0d", comp_q.size() - bc, 1);
        end else begin
            tests_run++;
            if ({start_q[bs].adr, start_q[bs].we, start_q[bs].dat} !== {8'h40, 1'b1, 32'h5}) begin
                tests_failed++; $display("FAIL write_fields: got %h/%b/%h expected 40/1/5", start_q[bs].adr, start_q[bs].we, start_q[bs].dat);
            end
            tests_run++;
            if ({comp_q[bc].done, comp_q[bc].err, comp_q[bc].gnt} !== {2'b01, 2'b00, 2'b01}) begin
                tests_failed++; $display("FAIL write_done: got done %b err %b gnt %b expected 01/00/01", comp_q[bc].done, comp_q[bc].err, comp_q[bc].gnt);
            end
            tests_run++;
            if (comp_q[bc].bus_len != 2 || comp_q[bc].cyc - start_q[bs].cyc != 2) begin
                tests_failed++; $display("FAIL write_latency: got len %0d gap %0d expected 2/2", comp_q[bc].bus_len, comp_q[bc].cyc - start_q[bs].cyc);
            end
        end
        req_want = '0;
        repeat (6) @(negedge wb_clk_i);
        tests_run++;
        if (comp_q.size() != bc + 1 || start_q.size() != bs + 1) begin
            tests_failed++; $display("FAIL write_single: got %0d done / %0d cyc expected 1/1", comp_q.size() - bc, start_q.size() - bs);
        end
    endtask

    task automatic test_read();
        int bs = start_q.size();
        int bc = comp_q.size();
        bit ok;
        set_req(1, 1'b0, 8'h04, 32'h0);
        slave_rand = 1'b0; ack_delay_cfg = 0; rd_data_cfg = 32'hDEAD_BEEF; auto_drop = 1'b1;
        req_want = 2'b10;
        wait_comps(bc + 1, 60, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL read_wait: got %0d completions expected 1", comp_q.size() - bc);
        end else begin
            tests_run++;
            if ({start_q[bs].adr, start_q[bs].we, start_q[bs].gnt} !== {8'h04, 1'b0, 2'b10}) begin
                tests_failed++; $display("FAIL read_fields: got %h/%b/%b expected 04/0/10", start_q[bs].adr, start_q[bs].we, start_q[bs].gnt);
            end
            tests_run++;
            if ({comp_q[bc].done, comp_q[bc].err, comp_q[bc].rdata} !== {2'b10, 2'b00, 32'hDEAD_BEEF}) begin
                tests_failed++; $display("FAIL read_done: got %b/%b/%h expected 10/00/deadbeef", comp_q[bc].done, comp_q[bc].err, comp_q[bc].rdata);
            end
        end
        req_want = '0;
        rd_data_cfg = 32'h0BAD_0BAD;
        repeat (4) @(negedge wb_clk_i);
        tests_run++;
        if (ifc.rdata_o !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL read_hold: got %h expected deadbeef", ifc.rdata_o);
        end
    endtask

    // Slave never acks (delay>=TIMEOUT) or acks on the last allowed cycle.
    task automatic run_limit(input string name, input int req, input int delay,
                             input logic [DATA_W-1:0] sdata);
        int bs = start_q.size();
        int bc = comp_q.size();
        bit ok;
        bit tmo = (delay >= TIMEOUT);
        logic [NUM_REQ-1:0] oh = NUM_REQ'(1) << req;
        set_req(req, 1'b0, 8'h10, 32'h0);
        slave_rand = 1'b0; ack_delay_cfg = delay; rd_data_cfg = sdata; auto_drop = 1'b1;
        req_want = oh;
        wait_comps(bc + 1, TIMEOUT + 40, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL %s_wait: got %0d completions expected 1", name, comp_q.size() - bc);
        end else begin
            tests_run++;
            if ({comp_q[bc].done, comp_q[bc].err} !== {oh, tmo ? oh : 2'b00}) begin
                tests_failed++; $display("FAIL %s_done_err: got %b/%b expected %b/%b", name, comp_q[bc].done, comp_q[bc].err, oh, tmo ? oh : 2'b00);
            end
            tests_run++;
            if (comp_q[bc].rdata !== (tmo ? 32'h0 : sdata)) begin
                tests_failed++; $display("FAIL %s_rdata: got %h expected %h", name, comp_q[bc].rdata, tmo ? 32'h0 : sdata);
            end
            tests_run++;
            if (comp_q[bc].bus_len != TIMEOUT || comp_q[bc].cyc - start_q[bs].cyc != TIMEOUT) begin
                tests_failed++; $display("FAIL %s_len: got %0d/%0d expected %0d", name, comp_q[bc].bus_len, comp_q[bc].cyc - start_q[bs].cyc, TIMEOUT);
            end
        end
        req_want = '0;
        repeat (3) @(negedge wb_clk_i);
    endtask

    task automatic test_timeout();
        run_limit("timeout", 0, 1000, 32'hFFFF_FFFF);
    endtask

    task automatic test_ack_at_limit();
        run_limit("ack_last", 1, TIMEOUT - 1, 32'h1234_5678);
        run_limit("ack_late", 0, TIMEOUT, 32'h5555_AAAA);
    endtask

    task automatic test_reset_mid();
        int bs = start_q.size();
        int bc;
        int n = 0;
        bit ok;
        set_req(0, 1'b0, 8'h20, 32'h0);
        set_req(1, 1'b1, 8'h24, 32'h77);
        slave_rand = 1'b0; ack_delay_cfg = 1000; auto_drop = 1'b1;
        req_want = 2'b01;
        while (start_q.size() == bs && n < 20) begin @(negedge wb_clk_i); n++; end
        tests_run++;
        if (start_q.size() == bs) begin
            tests_failed++; $display("FAIL rstmid_start: got no cycle expected one");
        end
        repeat (3) @(negedge wb_clk_i);
        bc = comp_q.size();
        wb_rst_i = 1'b0;
        ack_delay_cfg = 0;
        req_want = 2'b11;
        @(negedge wb_clk_i);
        tests_run++;
        if ({ifc.wb_cyc_o, ifc.wb_stb_o, ifc.gnt_o, ifc.done_o, ifc.err_o, ifc.wb_adr_o} !== '0) begin
            tests_failed++; $display("FAIL rstmid_outputs: got cyc %b gnt %b done %b err %b adr %h expected 0", ifc.wb_cyc_o, ifc.gnt_o, ifc.done_o, ifc.err_o, ifc.wb_adr_o);
        end
        repeat (2) @(negedge wb_clk_i);
        bs = start_q.size();
        wb_rst_i = 1'b1;
        wait_comps(bc + 2, 40, ok);
        tests_run++;
        if (!ok || comp_q[bc].done !== 2'b01 || start_q[bs].gnt !== 2'b01) begin
            tests_failed++; $display("FAIL rstmid_first_grant: got %0d completions, first done %b expected 01 without a done during reset", comp_q.size() - bc, ok ? comp_q[bc].done : 2'b00);
        end
        req_want = '0;
        repeat (4) @(negedge wb_clk_i);
    endtask

    task automatic test_back_to_back();
        int bs, bc;
        bit ok;
        wb_rst_i = 1'b0;
        set_req(0, 1'b1, 8'h30, 32'hA0);
        set_req(1, 1'b1, 8'h34, 32'hA1);
        slave_rand = 1'b0; ack_delay_cfg = 0; auto_drop = 1'b0;
        req_want = 2'b11;
        repeat (2) @(negedge wb_clk_i);
        bs = start_q.size();
        bc = comp_q.size();
        wb_rst_i = 1'b1;
        wait_comps(bc + 4, 40, ok);
        tests_run++;
        if (!ok || start_q.size() < bs + 4) begin
            tests_failed++; $display("FAIL b2b_wait: got %0d completions expected 4", comp_q.size() - bc);
        end else begin
            for (int j = 0; j < 4; j++) begin
                logic [NUM_REQ-1:0] oh = (j % 2 == 0) ? 2'b01 : 2'b10;
                tests_run++;
                if (start_q[bs+j].gnt !== oh || comp_q[bc+j].done !== oh || comp_q[bc+j].bus_len != 1) begin
                    tests_failed++; $display("FAIL b2b_grant%0d: got gnt %b done %b len %0d expected %b/%b/1", j, start_q[bs+j].gnt, comp_q[bc+j].done, comp_q[bc+j].bus_len, oh, oh);
                end
                if (j > 0) begin
                    tests_run++;
                    if (start_q[bs+j].cyc - start_q[bs+j-1].cyc != 3) begin
                        tests_failed++; $display("FAIL b2b_gap%0d: got %0d expected 3", j, start_q[bs+j].cyc - start_q[bs+j-1].cyc);
                    end
                end
            end
        end
        req_want = '0;
        auto_drop = 1'b1;
        repeat (6) @(negedge wb_clk_i);
    endtask

    task automatic test_random();
        int p = 0;
        logic [DATA_W-1:0] last_rdata = '0;
        logic [ADDR_W-1:0] f_adr [NUM_REQ];
        logic [DATA_W-1:0] f_dat [NUM_REQ];
        bit                f_we  [NUM_REQ];
        wb_rst_i = 1'b0;
        req_want = '0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        slave_rand = 1'b1; auto_drop = 1'b1;
        @(negedge wb_clk_i);
        for (int b = 0; b < 30; b++) begin
            int exp_q[$];
            int bs = start_q.size();
            int bc = comp_q.size();
            int n = 0;
            int scr = 0;
            int prev_len = 0;
            logic [NUM_REQ-1:0] mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                f_adr[i] = ADDR_W'($urandom); f_dat[i] = $urandom; f_we[i] = 1'($urandom_range(0, 1));
                set_req(i, f_we[i], f_adr[i], f_dat[i]);
            end
            for (int k = 0; k < NUM_REQ; k++)
                if (mask[(p + k) % NUM_REQ]) exp_q.push_back((p + k) % NUM_REQ);
            req_want = mask;
            // Once a transaction has started, its requester's fields are
            // scrambled; the latched values must still be on the bus.
            while (comp_q.size() < bc + exp_q.size() && n < 100) begin
                @(negedge wb_clk_i);
                n++;
                if (scr < exp_q.size() && start_q.size() > bs + scr) begin
                    set_req(exp_q[scr], 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
                    scr++;
                end
            end
            tests_run++;
            if (comp_q.size() < bc + exp_q.size() || start_q.size() < bs + exp_q.size()) begin
                tests_failed++; $display("FAIL rnd_wait b%0d: got %0d completions expected %0d", b, comp_q.size() - bc, exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    int o = exp_q[j];
                    start_t s = start_q[bs+j];
                    comp_t  c = comp_q[bc+j];
                    bit tmo = (s.delay >= TIMEOUT);
                    int len = tmo ? TIMEOUT : s.delay + 1;
                    logic [NUM_REQ-1:0] oh = NUM_REQ'(1) << o;
                    logic [DATA_W-1:0] exp_rd = tmo ? '0 : (f_we[o] ? last_rdata : s.sdata);
                    tests_run++;
                    if (s.gnt !== oh || {s.adr, s.dat, s.we} !== {f_adr[o], f_dat[o], f_we[o]}) begin
                        tests_failed++; $display("FAIL rnd_start b%0d t%0d: got gnt %b %h/%h/%b expected %b %h/%h/%b", b, j, s.gnt, s.adr, s.dat, s.we, oh, f_adr[o], f_dat[o], f_we[o]);
                    end
                    tests_run++;
                    if (c.done !== oh || c.gnt !== oh || c.err !== (tmo ? oh : '0)) begin
                        tests_failed++; $display("FAIL rnd_done b%0d t%0d: got done %b gnt %b err %b expected owner %b tmo %b", b, j, c.done, c.gnt, c.err, oh, tmo);
                    end
                    tests_run++;
                    if (c.bus_len != len || c.cyc - s.cyc != len || c.unstable) begin
                        tests_failed++; $display("FAIL rnd_len b%0d t%0d: got %0d/%0d unstable %b expected %0d", b, j, c.bus_len, c.cyc - s.cyc, c.unstable, len);
                    end
                    tests_run++;
                    if (c.rdata !== exp_rd) begin
                        tests_failed++; $display("FAIL rnd_rdata b%0d t%0d: got %h expected %h", b, j, c.rdata, exp_rd);
                    end
                    if (j > 0) begin
                        tests_run++;
                        if (s.cyc - start_q[bs+j-1].cyc != prev_len + 2) begin
                            tests_failed++; $display("FAIL rnd_gap b%0d t%0d: got %0d expected %0d", b, j, s.cyc - start_q[bs+j-1].cyc, prev_len + 2);
                        end
                    end
                    last_rdata = exp_rd;
                    prev_len = len;
                end
                p = (exp_q[exp_q.size() - 1] + 1) % NUM_REQ;
            end
            req_want = '0;
            repeat (3) @(negedge wb_clk_i);
            tests_run++;
            if ({ifc.wb_cyc_o, ifc.wb_we_o, ifc.wb_adr_o, ifc.wb_dat_o, ifc.gnt_o} !== '0) begin
                tests_failed++; $display("FAIL rnd_idle b%0d: got cyc %b adr %h dat %h gnt %b expected 0", b, ifc.wb_cyc_o, ifc.wb_adr_o, ifc.wb_dat_o, ifc.gnt_o);
            end
        end
        slave_rand = 1'b0;
    endtask

    initial begin
        ifc.req_we_i  = '0;
        ifc.req_adr_i = '0;
        ifc.req_dat_i = '0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_back_to_back();
        test_random();
        tests_run++;
        if (stb_bad != 0) begin
            tests_failed++; $display("FAIL stb_eq_cyc: got %0d differing cycles expected 0", stb_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge wb_clk_i);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
